// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of dat_mem: round-robin or locked ownership, lock timeout, registered read return.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: IDLE contention always favours requester 0.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out,
    output logic          lock_err
);

    // state | meaning
    // IDLE  | arbitrate between both requesters
    // OWN0  | requester 0 holds the lock, requester 1 stalled
    // OWN1  | requester 1 holds the lock, requester 0 stalled
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int CW = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] TMR_LOAD = CW'(LOCK_MAX - 1);

    state_t        state;
    logic [CW-1:0] lock_tmr;
    logic          acc0;
    logic          acc1;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic rr_last;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state)
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                        gnt0 = 1'b1;
`else
                        // The requester that did not go last wins the tie.
                        gnt0 = rr_last;
                        gnt1 = !rr_last;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign acc0       = req0 & gnt0;
    assign acc1       = req1 & gnt1;
    assign mem_addr   = gnt1 ? addr1 : addr0;
    assign mem_dat_in = gnt1 ? wdata1 : wdata0;
    assign mem_wr_en  = (acc0 & we0) | (acc1 & we1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lock_tmr <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            lock_err <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_last  <= 1'b1;
`endif
        end else begin
            rvalid0 <= acc0 & !we0;
            rvalid1 <= acc1 & !we1;
            if (acc0 && !we0) rdata0 <= mem_dat_out;
            if (acc1 && !we1) rdata1 <= mem_dat_out;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            if (acc0) rr_last <= 1'b0;
            if (acc1) rr_last <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (acc0 && lock0) begin
                        state    <= OWN0;
                        lock_tmr <= TMR_LOAD;
                    end else if (acc1 && lock1) begin
                        state    <= OWN1;
                        lock_tmr <= TMR_LOAD;
                    end
                end
                OWN0: begin
                    // A releasing access takes priority over the timeout.
                    if (acc0 && !lock0) begin
                        state <= IDLE;
                    end else if (lock_tmr == '0) begin
                        state    <= IDLE;
                        lock_err <= 1'b1;
                    end else begin
                        lock_tmr <= lock_tmr - 1'b1;
                    end
                end
                OWN1: begin
                    if (acc1 && !lock1) begin
                        state <= IDLE;
                    end else if (lock_tmr == '0) begin
                        state    <= IDLE;
                        lock_err <= 1'b1;
                    end else begin
                        lock_tmr <= lock_tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
